miss_line_fetch: RTL and testbench



---
 rtl/miss_line_fetch.sv | 127 ++++++++++++
 tb/tb_miss_line_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_line_fetch.sv
// Miss handler for the direct-mapped L1: fetches the four words of a missed block
// from word-addressed memory and hands the assembled line to the cache in one update.
module miss_line_fetch #(
   parameter int ADDR_W = 15,
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                miss,
   input  logic [ADDR_W-1:0]   missAddress,
   output logic                memRead,
   output logic [ADDR_W-1:0]   memAddress,
   input  logic                memReady,
   input  logic [WORD_W-1:0]   memData,
   output logic [4*WORD_W-1:0] lineData,
   output logic                lineValid,
   output logic                busy,
   output logic [CNT_W-1:0]    missCount
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          beat_q, beat_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [4*WORD_W-1:0] shadow_q, shadow_d;
   logic [4*WORD_W-1:0] line_q, line_d;
   logic                rd_q, rd_d;
   logic                vld_q, vld_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // The word offset of the miss is irrelevant: the whole block is always fetched.
   logic [1:0] unused_addr_lsbs;
   assign unused_addr_lsbs = missAddress[1:0];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         base_q   <= '0;
         addr_q   <= '0;
         shadow_q <= '0;
         line_q   <= '0;
         rd_q     <= 1'b0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         base_q   <= base_d;
         addr_q   <= addr_d;
         shadow_q <= shadow_d;
         line_q   <= line_d;
         rd_q     <= rd_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      addr_d   = addr_q;
      shadow_d = shadow_q;
      line_d   = line_q;
      rd_d     = rd_q;
      vld_d    = 1'b0;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (miss) begin
               base_d  = {missAddress[ADDR_W-1:2], 2'b00};
               beat_d  = 2'd0;
               addr_d  = base_d;
               rd_d    = 1'b1;
               cnt_d   = sat_inc(cnt_q);
               state_d = FETCH;
            end
         end
         FETCH: begin
            rd_d = 1'b1;
            if (memReady) begin
               shadow_d[beat_q*WORD_W +: WORD_W] = memData;
               if (beat_q == 2'd3) begin
                  // The last word goes straight into the line so the update is atomic.
                  line_d  = shadow_d;
                  vld_d   = 1'b1;
                  rd_d    = 1'b0;
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 2'd1;
                  addr_d = {base_q[ADDR_W-1:2], beat_d};
               end
            end
         end
         DONE: begin
            rd_d    = 1'b0;
            state_d = IDLE;
         end
         default: begin
            rd_d    = 1'b0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign memRead    = rd_q;
   assign memAddress = addr_q;
   assign lineData   = line_q;
   assign lineValid  = vld_q;
   assign busy       = busy_q;
   assign missCount  = cnt_q;

endmodule

// File: tb/tb_miss_line_fetch.sv
// Bench for miss_line_fetch: directed and randomized fills checked against a
// block-level model of memory, line assembly, timing and the saturating counter.
module tb_miss_line_fetch;

   localparam int ADDR_W = 15;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;
   localparam int CNT_MAX = 65535;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                miss = 1'b0;
   logic [ADDR_W-1:0]   missAddress = '0;
   logic                memRead;
   logic [ADDR_W-1:0]   memAddress;
   logic                memReady = 1'b0;
   logic [WORD_W-1:0]   memData;
   logic [4*WORD_W-1:0] lineData;
   logic                lineValid;
   logic                busy;
   logic [CNT_W-1:0]    missCount;

   // Small-counter instance used to reach saturation quickly
   logic                reset_s = 1'b1;
   logic                miss_s = 1'b0;
   logic [ADDR_W-1:0]   missAddress_s = 15'h0100;
   logic                memRead_s;
   logic [ADDR_W-1:0]   memAddress_s;
   logic                memReady_s = 1'b1;
   logic [WORD_W-1:0]   memData_s = 32'h5A5A_0001;
   logic [4*WORD_W-1:0] lineData_s;
   logic                lineValid_s;
   logic                busy_s;
   logic [3:0]          missCount_s;

   int nchecks = 0;
   int nerr    = 0;

   bit          mem_mode = 1'b0;
   logic [31:0] mem_seed = 32'h0;
   logic [4*WORD_W-1:0] exp_line = '0;
   int          exp_cnt = 0;

   function automatic logic [31:0] mem_of(input logic [14:0] w, input bit mode, input logic [31:0] seed);
      if (!mode) return 32'hA000_0000 + {17'b0, w};
      return ({17'b0, w} * 32'h9E37_79B1) ^ seed;
   endfunction

   assign memData = mem_of(memAddress, mem_mode, mem_seed);

   miss_line_fetch #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
      .clock(clock), .reset(reset), .miss(miss), .missAddress(missAddress),
      .memRead(memRead), .memAddress(memAddress), .memReady(memReady), .memData(memData),
      .lineData(lineData), .lineValid(lineValid), .busy(busy), .missCount(missCount)
   );

   miss_line_fetch #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(4)) u_sat (
      .clock(clock), .reset(reset_s), .miss(miss_s), .missAddress(missAddress_s),
      .memRead(memRead_s), .memAddress(memAddress_s), .memReady(memReady_s), .memData(memData_s),
      .lineData(lineData_s), .lineValid(lineValid_s), .busy(busy_s), .missCount(missCount_s)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete fill; st* = memReady-low cycles before each beat.
   task automatic run_fill(input logic [14:0] addr, input int s0, input int s1,
                           input int s2, input int s3, input bit hold);
      int st[4];
      logic [14:0] base;
      logic [127:0] want;
      int k, waitc, cyc, total;
      st = '{s0, s1, s2, s3};
      total = s0 + s1 + s2 + s3;
      base = addr & 15'h7FFC;
      for (int i = 0; i < 4; i++) want[i*32 +: 32] = mem_of(base + 15'(i), mem_mode, mem_seed);

      miss = 1'b1;
      missAddress = addr;
      memReady = 1'($urandom_range(0, 1));
      step();
      cyc = 1;
      if (exp_cnt < CNT_MAX) exp_cnt++;
      if (!hold) miss = 1'b0;
      k = 0;
      waitc = 0;
      while (k < 4 && cyc < 40) begin
         chk("memRead_fetch", memRead, 1'b1);
         chk("memAddress_fetch", memAddress, base + 15'(k));
         chk("lineValid_fetch", lineValid, 1'b0);
         chk("lineData_hold", lineData, exp_line);
         chk("busy_fetch", busy, 1'b1);
         chk("missCount_fetch", missCount, exp_cnt);
         if (hold) missAddress = 15'($urandom);
         if (waitc < st[k]) begin
            memReady = 1'b0;
            waitc++;
         end else begin
            memReady = 1'b1;
         end
         step();
         cyc++;
         if (memReady) begin
            k++;
            waitc = 0;
         end
      end
      chk("fetch_beats_done", k, 4);
      chk("lineValid_done", lineValid, 1'b1);
      chk("lineValid_cycle", cyc, 5 + total);
      chk("lineData_done", lineData, want);
      chk("memRead_done", memRead, 1'b0);
      chk("busy_done", busy, 1'b1);
      exp_line = want;
      memReady = 1'($urandom_range(0, 1));
      step();
      chk("lineValid_after", lineValid, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("lineData_after", lineData, exp_line);
      chk("missCount_after", missCount, exp_cnt);
   endtask

   initial begin
      int pulses;
      logic [14:0] b;

      // Reset state
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_memRead", memRead, 1'b0);
      chk("rst_memAddress", memAddress, 15'h0);
      chk("rst_lineData", lineData, 128'h0);
      chk("rst_lineValid", lineValid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_missCount", missCount, 16'h0);
      chk("rst_sat_count", missCount_s, 4'h0);

      // Basic fill, no waits
      run_fill(15'h1235, 0, 0, 0, 0, 1'b0);
      chk("basic_line", lineData,
          {32'hA000_1237, 32'hA000_1236, 32'hA000_1235, 32'hA000_1234});
      chk("basic_count", missCount, 16'd1);

      // Two wait cycles before every beat
      run_fill(15'h0456, 2, 2, 2, 2, 1'b0);

      // Top of the address space
      run_fill(15'h7FFF, 0, 1, 0, 0, 1'b0);
      chk("boundary_top_word", lineData[127:96], 32'hA000_7FFF);
      chk("boundary_low_word", lineData[31:0], 32'hA000_7FFC);

      // Miss held high through a fill, then back-to-back second fill
      run_fill(15'h2222, 0, 1, 0, 2, 1'b1);
      run_fill(15'h3333, 1, 0, 0, 0, 1'b0);
      chk("busy_miss_count", missCount, 16'd5);

      // Reset during beat 2
      b = 15'h4440;
      miss = 1'b1;
      missAddress = b;
      step();
      miss = 1'b0;
      memReady = 1'b1;
      step();
      step();
      chk("pre_reset_addr", memAddress, b + 15'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_memRead", memRead, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_lineData", lineData, 128'h0);
      chk("midrst_missCount", missCount, 16'h0);
      chk("midrst_lineValid", lineValid, 1'b0);
      exp_line = '0;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midrst_no_pulse", lineValid, 1'b0);
         chk("midrst_idle", busy, 1'b0);
      end

      // Reset coinciding with the final beat
      miss = 1'b1;
      missAddress = 15'h5550;
      step();
      miss = 1'b0;
      memReady = 1'b1;
      step();
      step();
      step();
      chk("pre_final_addr", memAddress, 15'h5553);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("finrst_lineValid", lineValid, 1'b0);
      chk("finrst_lineData", lineData, 128'h0);
      chk("finrst_missCount", missCount, 16'h0);
      chk("finrst_busy", busy, 1'b0);
      step();
      chk("finrst_no_pulse", lineValid, 1'b0);

      // Fill after reset completes normally
      run_fill(15'h0ABC, 0, 0, 1, 0, 1'b0);
      chk("post_reset_count", missCount, 16'd1);

      // Randomized fills over a hashed memory image
      mem_mode = 1'b1;
      mem_seed = $urandom;
      for (int n = 0; n < 12; n++) begin
         run_fill(15'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  (n == 11) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      miss = 1'b0;

      // Counter saturation on the 4-bit instance, miss and memReady held high
      reset_s = 1'b0;
      miss_s = 1'b1;
      pulses = 0;
      for (int c = 0; c < 300 && pulses < 20; c++) begin
         step();
         if (lineValid_s) begin
            pulses++;
            if (pulses == 14) chk("sat_count_14", missCount_s, 4'd14);
            if (pulses == 15) chk("sat_count_15", missCount_s, 4'd15);
            if (pulses == 16) chk("sat_count_16", missCount_s, 4'd15);
            if (pulses == 20) chk("sat_count_20", missCount_s, 4'd15);
         end
      end
      chk("sat_pulses", pulses, 20);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
